// File: rtl/tse_speed_ctrl.sv
// Per-port speed-mode controller for TSE MACs: synchronises PHY speed requests,
// debounces them and commits each new speed behind a MAC quiesce window.
module tse_speed_ctrl #(
  parameter int unsigned NUM_PORTS     = 2,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES   = 8
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [NUM_PORTS-1:0] set_10,
  input  logic [NUM_PORTS-1:0] set_1000,
  output logic [NUM_PORTS-1:0] eth_mode,
  output logic [NUM_PORTS-1:0] ena_10,
  output logic [NUM_PORTS-1:0] mac_en,
  output logic [NUM_PORTS-1:0] speed_chg,
  output logic [NUM_PORTS-1:0] busy
);

  localparam int unsigned CNT_MAX_VAL = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX_VAL + 1);
  localparam logic [CNT_W-1:0] STABLE_C  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit PARAMS_OK = (NUM_PORTS >= 1) && (NUM_PORTS <= 8) &&
                             (SYNC_STAGES >= 2) && (SYNC_STAGES <= 4) &&
                             (STABLE_CYCLES >= 1) && (HOLD_CYCLES >= 1);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_QUALIFY = 2'd2,
    ST_QUIESCE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SPD_H = 2'b00,
    SPD_T = 2'b01,
    SPD_G = 2'b10
  } speed_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  // Synchroniser chains; vld_q tracks pipeline fill so INIT ignores pre-reset garbage
  logic [SYNC_STAGES-1:0] s10_q   [NUM_PORTS];
  logic [SYNC_STAGES-1:0] s1000_q [NUM_PORTS];
  logic [SYNC_STAGES-1:0] vld_q   [NUM_PORTS];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        s10_q[p]   <= '0;
        s1000_q[p] <= '0;
        vld_q[p]   <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        s10_q[p]   <= {s10_q[p][SYNC_STAGES-2:0], set_10[p]};
        s1000_q[p] <= {s1000_q[p][SYNC_STAGES-2:0], set_1000[p]};
        vld_q[p]   <= {vld_q[p][SYNC_STAGES-2:0], 1'b1};
      end
    end
  end

  speed_e               req_c [NUM_PORTS];
  logic [NUM_PORTS-1:0] req_vld_c;

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      req_vld_c[p] = vld_q[p][SYNC_STAGES-1];
      if (s1000_q[p][SYNC_STAGES-1]) begin
        req_c[p] = SPD_G;
      end else if (s10_q[p][SYNC_STAGES-1]) begin
        req_c[p] = SPD_T;
      end else begin
        req_c[p] = SPD_H;
      end
    end
  end

  state_e               state_q [NUM_PORTS];
  state_e               state_d [NUM_PORTS];
  speed_e               cand_q  [NUM_PORTS];
  speed_e               cand_d  [NUM_PORTS];
  speed_e               comm_q  [NUM_PORTS];
  speed_e               comm_d  [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_q   [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_d   [NUM_PORTS];
  logic [NUM_PORTS-1:0] eth_mode_q, eth_mode_d;
  logic [NUM_PORTS-1:0] ena_10_q, ena_10_d;
  logic [NUM_PORTS-1:0] mac_en_q, mac_en_d;
  logic [NUM_PORTS-1:0] speed_chg_q, speed_chg_d;
  logic [NUM_PORTS-1:0] busy_q, busy_d;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= ST_INIT;
        cand_q[p]  <= SPD_H;
        comm_q[p]  <= SPD_H;
        cnt_q[p]   <= '0;
      end
      eth_mode_q  <= '0;
      ena_10_q    <= '0;
      mac_en_q    <= '0;
      speed_chg_q <= '0;
      busy_q      <= '1;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      comm_q      <= comm_d;
      cnt_q       <= cnt_d;
      eth_mode_q  <= eth_mode_d;
      ena_10_q    <= ena_10_d;
      mac_en_q    <= mac_en_d;
      speed_chg_q <= speed_chg_d;
      busy_q      <= busy_d;
    end
  end

  // Per-port next state; cnt_q counts qualification cycles, then quiesce cycles
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    comm_d      = comm_q;
    cnt_d       = cnt_q;
    mac_en_d    = mac_en_q;
    speed_chg_d = '0;
    eth_mode_d  = eth_mode_q;
    ena_10_d    = ena_10_q;
    busy_d      = busy_q;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      case (state_q[p])
        ST_INIT: begin
          if (req_vld_c[p]) begin
            if (req_c[p] != cand_q[p]) begin
              cand_d[p] = req_c[p];
              cnt_d[p]  = CNT_ONE;
            end else begin
              cnt_d[p] = sat_inc(cnt_q[p]);
            end
            if (cnt_d[p] >= STABLE_C) begin
              state_d[p]     = ST_ACTIVE;
              comm_d[p]      = cand_d[p];
              cnt_d[p]       = '0;
              mac_en_d[p]    = 1'b1;
              speed_chg_d[p] = 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (req_c[p] != comm_q[p]) begin
            state_d[p] = ST_QUALIFY;
            cand_d[p]  = req_c[p];
            cnt_d[p]   = CNT_ONE;
            if (CNT_ONE >= STABLE_C) begin
              state_d[p]  = ST_QUIESCE;
              cnt_d[p]    = '0;
              mac_en_d[p] = 1'b0;
            end
          end
        end
        ST_QUALIFY: begin
          if (req_c[p] == comm_q[p]) begin
            state_d[p] = ST_ACTIVE;
            cnt_d[p]   = '0;
          end else begin
            if (req_c[p] != cand_q[p]) begin
              cand_d[p] = req_c[p];
              cnt_d[p]  = CNT_ONE;
            end else begin
              cnt_d[p] = sat_inc(cnt_q[p]);
            end
            if (cnt_d[p] >= STABLE_C) begin
              state_d[p]  = ST_QUIESCE;
              cnt_d[p]    = '0;
              mac_en_d[p] = 1'b0;
            end
          end
        end
        ST_QUIESCE: begin
          mac_en_d[p] = 1'b0;
          if (cnt_q[p] == HOLD_LAST) begin
            state_d[p]     = ST_ACTIVE;
            comm_d[p]      = cand_q[p];
            cnt_d[p]       = '0;
            mac_en_d[p]    = 1'b1;
            speed_chg_d[p] = 1'b1;
          end else begin
            cnt_d[p] = sat_inc(cnt_q[p]);
          end
        end
        default: begin
          state_d[p] = ST_INIT;
          cnt_d[p]   = '0;
        end
      endcase
      eth_mode_d[p] = (comm_d[p] == SPD_G);
      ena_10_d[p]   = (comm_d[p] == SPD_T);
      busy_d[p]     = (state_d[p] != ST_ACTIVE);
    end
  end

  assign eth_mode  = eth_mode_q;
  assign ena_10    = ena_10_q;
  assign mac_en    = mac_en_q;
  assign speed_chg = speed_chg_q;
  assign busy      = busy_q;

  a_params_legal: assert property (@(posedge clk_clk) PARAMS_OK)
    else $error("tse_speed_ctrl: illegal parameter set");

endmodule

// File: tb/tb_tse_speed_ctrl.sv
// Directed bench for tse_speed_ctrl with default parameters (2 ports, 2 sync, 16 stable, 8 hold).
module tb_tse_speed_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] set_10 = 2'b00;
  logic [1:0] set_1000 = 2'b00;
  logic [1:0] eth_mode, ena_10, mac_en, speed_chg, busy;

  int errors = 0;
  int checks = 0;

  tse_speed_ctrl #(
    .NUM_PORTS(2), .SYNC_STAGES(2), .STABLE_CYCLES(16), .HOLD_CYCLES(8)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .set_10(set_10), .set_1000(set_1000),
    .eth_mode(eth_mode), .ena_10(ena_10), .mac_en(mac_en),
    .speed_chg(speed_chg), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset values, then INIT commit 2+16 cycles after release (port0 G, port1 H)
  task automatic test_reset;
    logic [9:0] exp;
    set_10 = 2'b00; set_1000 = 2'b01; rst_n = 1'b0;
    tick(2);
    checks++;
    if ({mac_en, speed_chg, eth_mode, ena_10, busy} !== 10'b00_00_00_00_11) begin
      errors++;
      $display("FAIL reset_values: got mac=%b chg=%b eth=%b ena=%b busy=%b, exp mac=00 chg=00 eth=00 ena=00 busy=11",
               mac_en, speed_chg, eth_mode, ena_10, busy);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick(1);
      if (i < 18)       exp = 10'b00_00_00_00_11;
      else if (i == 18) exp = 10'b11_11_01_00_00;
      else              exp = 10'b11_00_01_00_00;
      checks++;
      if ({mac_en, speed_chg, eth_mode, ena_10, busy} !== exp) begin
        errors++;
        $display("FAIL init_commit cyc %0d: got {mac,chg,eth,ena,busy}=%b exp %b", i,
                 {mac_en, speed_chg, eth_mode, ena_10, busy}, exp);
      end
    end
  endtask

  // Port0 G -> T: mac_en low for cycles 18..25, commit at 26; port1 untouched
  task automatic test_active_change;
    logic [9:0] exp;
    set_1000[0] = 1'b0; set_10[0] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      exp[9:8] = (i >= 18 && i <= 25) ? 2'b10 : 2'b11;
      exp[7:6] = (i == 26) ? 2'b01 : 2'b00;
      exp[5:4] = (i < 26) ? 2'b01 : 2'b00;
      exp[3:2] = (i < 26) ? 2'b00 : 2'b01;
      exp[1:0] = (i >= 3 && i <= 25) ? 2'b01 : 2'b00;
      checks++;
      if ({mac_en, speed_chg, eth_mode, ena_10, busy} !== exp) begin
        errors++;
        $display("FAIL active_change cyc %0d: got {mac,chg,eth,ena,busy}=%b exp %b", i,
                 {mac_en, speed_chg, eth_mode, ena_10, busy}, exp);
      end
    end
  endtask

  // 10-cycle set_1000 glitch on port1 at H: QUALIFY entered and left, nothing committed
  task automatic test_glitch;
    logic [9:0] exp;
    set_1000[1] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      exp = {2'b11, 2'b00, 2'b00, 2'b01, ((i >= 3 && i <= 12) ? 2'b10 : 2'b00)};
      checks++;
      if ({mac_en, speed_chg, eth_mode, ena_10, busy} !== exp) begin
        errors++;
        $display("FAIL glitch cyc %0d: got {mac,chg,eth,ena,busy}=%b exp %b", i,
                 {mac_en, speed_chg, eth_mode, ena_10, busy}, exp);
      end
      if (i == 10) set_1000[1] = 1'b0;
    end
  endtask

  // Port1 H -> T (5 cycles) -> G: count restarts, quiesce 18 after G change, commit 26 after
  task automatic test_flip_flop;
    logic [9:0] exp;
    set_10[1] = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      tick(1);
      exp[9:8] = (i >= 23 && i <= 30) ? 2'b01 : 2'b11;
      exp[7:6] = (i == 31) ? 2'b10 : 2'b00;
      exp[5:4] = (i >= 31) ? 2'b10 : 2'b00;
      exp[3:2] = 2'b01;
      exp[1:0] = (i >= 3 && i <= 30) ? 2'b10 : 2'b00;
      checks++;
      if ({mac_en, speed_chg, eth_mode, ena_10, busy} !== exp) begin
        errors++;
        $display("FAIL flip_flop cyc %0d: got {mac,chg,eth,ena,busy}=%b exp %b", i,
                 {mac_en, speed_chg, eth_mode, ena_10, busy}, exp);
      end
      if (i == 5) begin
        set_10[1] = 1'b0; set_1000[1] = 1'b1;
      end
    end
  endtask

  // Reset pulse while port0 quiesces T -> H; full INIT rerun (port0 H, port1 G)
  task automatic test_reset_quiesce;
    logic [9:0] exp;
    set_10[0] = 1'b0;
    tick(22);
    checks++;
    if ({mac_en, busy} !== 4'b10_01) begin
      errors++;
      $display("FAIL pre_reset_quiesce: got mac=%b busy=%b exp mac=10 busy=01", mac_en, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mac_en, speed_chg, eth_mode, ena_10, busy} !== 10'b00_00_00_00_11) begin
      errors++;
      $display("FAIL async_reset: got {mac,chg,eth,ena,busy}=%b exp 0000000011",
               {mac_en, speed_chg, eth_mode, ena_10, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i < 18)       exp = 10'b00_00_00_00_11;
      else if (i == 18) exp = 10'b11_11_10_00_00;
      else              exp = 10'b11_00_10_00_00;
      checks++;
      if ({mac_en, speed_chg, eth_mode, ena_10, busy} !== exp) begin
        errors++;
        $display("FAIL reinit cyc %0d: got {mac,chg,eth,ena,busy}=%b exp %b", i,
                 {mac_en, speed_chg, eth_mode, ena_10, busy}, exp);
      end
    end
  endtask

  // Both set bits -> G; switch to H mid-quiesce: G commits first, then H is qualified
  task automatic test_both_set;
    logic [9:0] exp;
    set_10[0] = 1'b1; set_1000[0] = 1'b1;
    for (int i = 1; i <= 54; i++) begin
      tick(1);
      exp[9:8] = ((i >= 18 && i <= 25) || (i >= 42 && i <= 49)) ? 2'b10 : 2'b11;
      exp[7:6] = (i == 26 || i == 50) ? 2'b01 : 2'b00;
      exp[5:4] = (i >= 26 && i <= 49) ? 2'b11 : 2'b10;
      exp[3:2] = 2'b00;
      exp[1:0] = ((i >= 3 && i <= 25) || (i >= 27 && i <= 49)) ? 2'b01 : 2'b00;
      checks++;
      if ({mac_en, speed_chg, eth_mode, ena_10, busy} !== exp) begin
        errors++;
        $display("FAIL both_set cyc %0d: got {mac,chg,eth,ena,busy}=%b exp %b", i,
                 {mac_en, speed_chg, eth_mode, ena_10, busy}, exp);
      end
      if (i == 20) begin
        set_10[0] = 1'b0; set_1000[0] = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_active_change();
    test_glitch();
    test_flip_flop();
    test_reset_quiesce();
    test_both_set();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
